// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings and default width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must reach WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell; port order (Cout, S, A, B, Cin).
module fulladder (
    output logic Cout,
    output logic S,
    input  logic A,
    input  logic B,
    input  logic Cin
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, one bit per clock through a single full adder, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_c;

    fulladder u_fa (
        .Cout(fa_c),
        .S   (fa_s),
        .A   (a_reg[0]),
        .B   (b_reg[0]),
        .Cin (carry_reg)
    );

    assign sum = sum_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        cnt       <= '0;
                        sum_reg   <= '0;
                        cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf       <= 1'b0;
`endif
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    sum_reg   <= {fa_s, sum_reg[WIDTH-1:1]};
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    carry_reg <= fa_c;
                    cnt       <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        // carry_reg here is the carry into the MSB
                        cout  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= carry_reg ^ fa_c;
`endif
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/sum width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an addition.
REQ-005 SHALL have port a  input  WIDTH  operand A, sampled when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  operand B, sampled when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in, sampled when start is accepted.
REQ-008 SHALL have port busy  output  1  high while an addition is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when sum/cout are valid.
REQ-010 SHALL have port sum  output  WIDTH  result, LSB-first serial accumulation.
REQ-011 SHALL have port cout  output  1  final carry-out.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 IDLE: start=1 at an edge SHALL capture a, b and cin into a_reg, b_reg and carry_reg, clear bit counter, clear sum_reg, and enter SHIFT.
REQ-014 SHIFT: each edge SHALL add a_reg[0]+b_reg[0]+carry_reg, shift sum bit into sum_reg MSB, shift a_reg/b_reg right by one, load cout into carry_reg, and increment counter.
REQ-015 SHIFT SHALL go to DONE on the edge that processes bit WIDTH-1 (exactly WIDTH SHIFT edges).
REQ-016 DONE SHALL last one cycle with done=1, then go to IDLE unconditionally.
REQ-017 Latency SHALL be WIDTH+1 edges from the accepting edge to done high.
REQ-018 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-019 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-020 sum and cout SHALL hold their last result from DONE until the next accepted start clears them.
REQ-021 Arithmetic SHALL be unsigned modulo 2^WIDTH, with carry beyond MSB reported only on cout.
REQ-022 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-023 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, all internal registers=0, independent of clk.
REQ-024 rst asserted mid-operation SHALL abort it; no done pulse SHALL be produced for the aborted operation.
REQ-025 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-026 Macro SERIAL_ADDER_OVF_EN defined SHALL add output ovf (1 bit) = signed overflow, computed as carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, valid and held like cout, reset to 0.
REQ-027 Without SERIAL_ADDER_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Shared package serial_adder_pkg SHALL hold the FSM state encodings (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the default WIDTH constant.
REQ-029 The per-bit add SHALL instantiate the team's existing fulladder cell, port order (Cout,S,A,B,Cin), as the single sub-module; no behavioural "+" on the datapath.

Verification
REQ-030 WIDTH=8, a=0x0F, b=0x01, cin=0, start pulse -> done exactly 9 edges later, sum=0x10, cout=0.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0 when enabled.
REQ-032 a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1 when enabled.
REQ-033 Hold start=1 continuously with a=0x03, b=0x04 -> first result sum=0x07; starts during busy ignored; next operation accepted only on an edge in IDLE.
REQ-034 Assert rst 4 edges into SHIFT -> outputs 0 immediately, no done pulse; then a=0xAA, b=0x55, cin=1 -> sum=0x00, cout=1.
REQ-035 Exhaustive run at WIDTH=2 over all a, b and cin values -> {cout,sum} equals a+b+cin in every case.
